// File: rtl/regfile_if.sv
// Register-file bus: one write port (write-back) and two read ports (operand fetch).
interface regfile_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read1_enable;
  logic [ADDR_WIDTH-1:0] read1_address;
  logic [DATA_WIDTH-1:0] read1_data;
  logic                  read2_enable;
  logic [ADDR_WIDTH-1:0] read2_address;
  logic [DATA_WIDTH-1:0] read2_data;

  // Pipeline side: drives writes and read requests, consumes operands.
  modport master (
    output write_enable, write_address, write_data,
    output read1_enable, read1_address, read2_enable, read2_address,
    input  read1_data, read2_data
  );

  // Register file side.
  modport slave (
    input  write_enable, write_address, write_data,
    input  read1_enable, read1_address, read2_enable, read2_address,
    output read1_data, read2_data
  );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: 32 x 32-bit, $0 hardwired to zero,
// synchronous write, two combinational read ports with same-cycle write bypass.
module regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32
) (
  input logic       clock,
  input logic       reset,
  regfile_if.slave  bus
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  // Clear on reset; otherwise commit write-back, dropping writes to $0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_enable && (bus.write_address != '0)) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  // Port 1 operand: reset, disable and $0 force zero; a matching write is bypassed.
  always_comb begin
    bus.read1_data = '0;
    if (reset || !bus.read1_enable || (bus.read1_address == '0)) begin
      bus.read1_data = '0;
    end else if (bus.write_enable && (bus.write_address == bus.read1_address)) begin
      bus.read1_data = bus.write_data;
    end else begin
      bus.read1_data = regs[bus.read1_address];
    end
  end

  // Port 2 operand: identical and independent of port 1.
  always_comb begin
    bus.read2_data = '0;
    if (reset || !bus.read2_enable || (bus.read2_address == '0)) begin
      bus.read2_data = '0;
    end else if (bus.write_enable && (bus.write_address == bus.read2_address)) begin
      bus.read2_data = bus.write_data;
    end else begin
      bus.read2_data = regs[bus.read2_address];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.write_enable  = en;
    bus.write_address = addr;
    bus.write_data    = data;
  endtask

  task automatic set_reads(input logic e1, input logic [4:0] a1,
                           input logic e2, input logic [4:0] a2);
    bus.read1_enable  = e1;
    bus.read1_address = a1;
    bus.read2_enable  = e2;
    bus.read2_address = a2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_write(1'b1, 5'd5, 32'hCAFE_F00D);
    set_reads(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_r1_during: got %h want %h", bus.read1_data, 32'h0);
    end
    vectors++;
    if (bus.read2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_r2_during: got %h want %h", bus.read2_data, 32'h0);
    end
    tick();
    reset = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_r1_after: got %h want %h", bus.read1_data, 32'h0);
    end
    // Reset clear: write DEADBEEF to $5 then pulse reset.
    set_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL reset_clear_pre: got %h want %h", bus.read1_data, 32'hDEAD_BEEF);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clear_during: got %h want %h", bus.read1_data, 32'h0);
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clear_after: got %h want %h", bus.read1_data, 32'h0);
    end
  endtask

  task automatic test_write_read();
    set_write(1'b1, 5'd7, 32'h1234_5678);
    set_reads(1'b1, 5'd1, 1'b1, 5'd2);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_read_r1: got %h want %h", bus.read1_data, 32'h1234_5678);
    end
    vectors++;
    if (bus.read2_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_read_r2: got %h want %h", bus.read2_data, 32'h1234_5678);
    end
  endtask

  task automatic test_bypass();
    set_write(1'b1, 5'd4, 32'h0000_0001);
    tick();
    set_write(1'b1, 5'd3, 32'hA5A5_A5A5);
    set_reads(1'b1, 5'd3, 1'b1, 5'd4);
    #1;
    vectors++;
    if (bus.read1_data !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_r1: got %h want %h", bus.read1_data, 32'hA5A5_A5A5);
    end
    vectors++;
    if (bus.read2_data !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL bypass_r2_other: got %h want %h", bus.read2_data, 32'h1);
    end
    // Both ports on the bypassed address.
    set_reads(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    vectors++;
    if (bus.read2_data !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_r2_same: got %h want %h", bus.read2_data, 32'hA5A5_A5A5);
    end
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_stored: got %h want %h", bus.read1_data, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_zero_register();
    set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_reads(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_r1_same_cycle: got %h want %h", bus.read1_data, 32'h0);
    end
    vectors++;
    if (bus.read2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_r2_same_cycle: got %h want %h", bus.read2_data, 32'h0);
    end
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_r1_next: got %h want %h", bus.read1_data, 32'h0);
    end
  endtask

  task automatic test_read_disable();
    set_write(1'b1, 5'd9, 32'h0000_0055);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b1, 5'd9, 1'b0, 5'd9);
    #1;
    vectors++;
    if (bus.read2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL disable_r2_off: got %h want %h", bus.read2_data, 32'h0);
    end
    vectors++;
    if (bus.read1_data !== 32'h55) begin
      miscompares++;
      $display("FAIL disable_r1_on: got %h want %h", bus.read1_data, 32'h55);
    end
    bus.read2_enable = 1'b1;
    #1;
    vectors++;
    if (bus.read2_data !== 32'h55) begin
      miscompares++;
      $display("FAIL disable_r2_raised: got %h want %h", bus.read2_data, 32'h55);
    end
    // Disabled port also ignores bypass.
    bus.read1_enable = 1'b0;
    set_write(1'b1, 5'd9, 32'h0000_0066);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL disable_r1_bypass: got %h want %h", bus.read1_data, 32'h0);
    end
    tick();
    set_write(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_collision();
    set_write(1'b1, 5'd2, 32'h0000_0011);
    tick();
    reset = 1'b1;
    set_write(1'b1, 5'd2, 32'h0000_0077);
    set_reads(1'b1, 5'd2, 1'b1, 5'd2);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL collision_during: got %h want %h", bus.read1_data, 32'h0);
    end
    tick();
    reset = 1'b0;
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL collision_after: got %h want %h", bus.read2_data, 32'h0);
    end
    // First edge with reset low accepts a write.
    set_write(1'b1, 5'd2, 32'h0000_0099);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h99) begin
      miscompares++;
      $display("FAIL collision_first_write: got %h want %h", bus.read1_data, 32'h99);
    end
  endtask

  task automatic test_back_to_back();
    set_reads(1'b1, 5'd10, 1'b1, 5'd10);
    set_write(1'b1, 5'd10, 32'h1111_1111);
    tick();
    set_write(1'b1, 5'd10, 32'h2222_2222);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL b2b_between: got %h want %h", bus.read1_data, 32'h2222_2222);
    end
    // Write elsewhere: port shows stored first value.
    set_write(1'b1, 5'd11, 32'h3333_3333);
    #1;
    vectors++;
    if (bus.read2_data !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL b2b_stored_first: got %h want %h", bus.read2_data, 32'h1111_1111);
    end
    set_write(1'b1, 5'd10, 32'h2222_2222);
    tick();
    set_write(1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL b2b_after: got %h want %h", bus.read1_data, 32'h2222_2222);
    end
    // Earlier registers untouched by later traffic.
    set_reads(1'b1, 5'd7, 1'b1, 5'd4);
    #1;
    vectors++;
    if (bus.read1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_r7_cleared: got %h want %h", bus.read1_data, 32'h0);
    end
    vectors++;
    if (bus.read2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_r4_cleared: got %h want %h", bus.read2_data, 32'h0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    set_write(1'b0, 5'd0, 32'h0);
    set_reads(1'b0, 5'd0, 1'b0, 5'd0);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_register();
    test_read_disable();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS pipeline: 32 × 32-bit registers, one synchronous write port, two combinational read ports. The write port is the write-back end of the `write_address`/`write_enable`/`write_data` triple produced by the execute stage and carried through the pipeline. The read ports feed the decode stage's operand fetch. Register `$0` is hardwired to zero, and same-cycle writes are bypassed to the read ports so that decode never observes stale data for a register being written back.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width (matches `REGS_DATA_BUS`)
- `ADDR_WIDTH`, 5, register index width (matches `REGS_ADDR_BUS`)
- `REG_COUNT`, 32, number of architectural registers (2^`ADDR_WIDTH`)

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous active-high reset, asserted level `ENABLE`
- `write_enable`  in  1  commit `write_data` to `write_address` at next rising edge
- `write_address`  in  `ADDR_WIDTH`  destination register index
- `write_data`  in  `DATA_WIDTH`  value to commit
- `read1_enable`  in  1  port-1 read request
- `read1_address`  in  `ADDR_WIDTH`  port-1 register index
- `read1_data`  out  `DATA_WIDTH`  port-1 operand (combinational)
- `read2_enable`  in  1  port-2 read request
- `read2_address`  in  `ADDR_WIDTH`  port-2 register index
- `read2_data`  out  `DATA_WIDTH`  port-2 operand (combinational)

## Operation
- Storage: array `regs[0..REG_COUNT-1]` of `DATA_WIDTH` bits.
- Reset:
  - On a rising edge with `reset` high, every entry is cleared to 0.
  - A write presented in the same cycle is discarded.
- Write:
  - On a rising edge with `reset` low, `write_enable` high and `write_address != 0`: `regs[write_address] <= write_data`.
  - Writes to index 0 are silently dropped; `regs[0]` stays 0 forever.
- Read, port N (both ports identical and independent), priority order:
  1. `reset` high → `readN_data = 0`.
  2. `readN_enable` low → 0.
  3. `readN_address == 0` → 0.
  4. `write_enable` high and `write_address == readN_address` → `write_data` (bypass).
  5. Otherwise → `regs[readN_address]`.
- Both ports may read the same address, including simultaneously with a bypassed write; both return the same value.
- No arithmetic. All widths are exact; no truncation or extension takes place.
- No state machine. The only sequential state is the register array.

## Timing
- Read latency: 0 cycles (purely combinational from address, enable, write-port and reset inputs to `readN_data`).
- Write latency:
  - Visible on the read ports in the same cycle via bypass.
  - Visible from the array from the cycle after the commit edge.
- Output values during and after reset:
  - While `reset` is high, both read outputs are 0 regardless of other inputs.
  - After the first edge with `reset` high, all registers read 0 until written.
- Reset mid-operation:
  - Reset asserted in the same cycle as a write: the write is lost and the register reads 0 after the edge.
  - Reset deasserted: the first write is accepted on the first edge with `reset` low.
- Back-to-back writes to one address: the last edge wins. A read in the cycle between them shows the bypassed second value; a read after both shows the stored second value.
- No handshake: the write port has no backpressure, and the pipeline guarantees one write per cycle at most.

## Test plan
- **Reset clear:** write `0xDEADBEEF` to `$5`, then pulse `reset` for 1 cycle → `read1_data` on `$5` = 0 during reset and after it.
- **Write then read:** cycle 0 write `$7 = 0x12345678`; cycle 1 read `$7` on both ports → both = `0x12345678`.
- **Same-cycle bypass:** `write_enable`=1, `$3 = 0xA5A5A5A5`, `read1_address`=3, `read2_address`=4 with `$4` holding `0x1` → `read1_data` = `0xA5A5A5A5` in the same cycle, `read2_data` = `0x1`.
- **Zero register:** write `$0 = 0xFFFFFFFF`, read `$0` in the same cycle and the next → always 0, and the bypass does not fire.
- **Read disable:** `$9` holds `0x55`, `read2_enable`=0, address 9 → `read2_data` = 0; raise enable → `0x55` with no cycle delay.
- **Reset versus write collision:** `reset`=1 together with write `$2 = 0x77` → after the edge, `$2` reads 0.
